// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch debouncer channels.
// Provides stable-count presets, the counter-width helper and the channel state type.
package debounce_pkg;

    localparam int DEB_STABLE_SIM   = 4;
    localparam int DEB_STABLE_BOARD = 1_000_000;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

    // Width needed to hold 0..stable_cycles, never less than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, stability counter and registered
// level/edge outputs. The state is implicit: pending whenever s2 differs from dout.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    deb_state_t    state;

    // Deriving the state from s2 vs dout lets the count start on the same edge
    // the new level first appears in s2, which keeps latency at STABLE_CYCLES+2.
    assign state = (s2 != dout) ? ST_PENDING : ST_STABLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values;
            // blocking here would collapse the two synchronizer stages into one.
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: cnt <= '0;
                ST_PENDING: begin
                    if (cnt == CNT_LAST) begin
                        dout <= s2;
                        cnt  <= '0;
                        rise <= s2;
                        fall <= ~s2;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch synchronizer/debouncer: one independent
// debounce_channel per input bit, no shared state.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = DEB_STABLE_SIM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .din  (sw_in[i]),
            .dout (sw_out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer (WIDTH=2, STABLE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_switch_debouncer;

    logic       clk;
    logic       rst;
    logic [1:0] sw_in;
    logic [1:0] sw_out;
    logic [1:0] rise;
    logic [1:0] fall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    switch_debouncer #(
        .WIDTH         (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .rise   (rise),
        .fall   (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset held 3 edges with inputs high, then the 6th edge after release updates.
    task automatic test_reset();
        sw_in = 2'b11;
        rst   = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total_cnt++;
            if ({sw_out, rise, fall} !== 6'b0)
                $display("FAIL reset_hold edge %0d: out=%b rise=%b fall=%b, want all 0", e, sw_out, rise, fall);
            else
                pass_cnt++;
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] exp_out, exp_rise;
            tick();
            exp_out  = (e >= 6) ? 2'b11 : 2'b00;
            exp_rise = (e == 6) ? 2'b11 : 2'b00;
            total_cnt++;
            if ({sw_out, rise, fall} !== {exp_out, exp_rise, 2'b00})
                $display("FAIL reset_release edge %0d: out=%b rise=%b fall=%b, want out=%b rise=%b fall=00",
                         e, sw_out, rise, fall, exp_out, exp_rise);
            else
                pass_cnt++;
        end
    endtask

    // Channel 0 steps 0->1 and is held; update on the 6th edge counting the capture edge.
    task automatic test_clean_step();
        sw_in = 2'b00;
        settle(10);
        total_cnt++;
        if (sw_out !== 2'b00)
            $display("FAIL clean_step_prep: out=%b, want 00", sw_out);
        else
            pass_cnt++;
        sw_in = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] exp_out, exp_rise;
            tick();
            exp_out  = (e >= 6) ? 2'b01 : 2'b00;
            exp_rise = (e == 6) ? 2'b01 : 2'b00;
            total_cnt++;
            if ({sw_out, rise, fall} !== {exp_out, exp_rise, 2'b00})
                $display("FAIL clean_step edge %0d: out=%b rise=%b fall=%b, want out=%b rise=%b fall=00",
                         e, sw_out, rise, fall, exp_out, exp_rise);
            else
                pass_cnt++;
        end
    endtask

    // Channel 0 toggles every 2 cycles for 20 cycles, then holds its original level.
    task automatic test_bounce_reject();
        for (int c = 0; c < 28; c++) begin
            if (c < 20)
                sw_in[0] = ((c / 2) % 2 == 1);
            else
                sw_in[0] = 1'b1;
            tick();
            total_cnt++;
            if ({sw_out, rise, fall} !== {2'b01, 2'b00, 2'b00})
                $display("FAIL bounce_reject cycle %0d: out=%b rise=%b fall=%b, want out=01 rise=00 fall=00",
                         c, sw_out, rise, fall);
            else
                pass_cnt++;
        end
    endtask

    // Channel 1 bounces 1,0,1,0,1 then holds 1; exactly one rise, 6th edge after final 1 captured.
    task automatic test_bounce_settle();
        logic [4:0] pattern;
        pattern = 5'b10101;
        for (int i = 0; i < 4; i++) begin
            sw_in[1] = pattern[i];
            tick();
            total_cnt++;
            if ({sw_out, rise, fall} !== {2'b01, 2'b00, 2'b00})
                $display("FAIL bounce_settle pattern %0d: out=%b rise=%b fall=%b, want out=01 rise=00 fall=00",
                         i, sw_out, rise, fall);
            else
                pass_cnt++;
        end
        sw_in[1] = pattern[4];
        for (int e = 1; e <= 9; e++) begin
            logic [1:0] exp_out, exp_rise;
            tick();
            exp_out  = (e >= 6) ? 2'b11 : 2'b01;
            exp_rise = (e == 6) ? 2'b10 : 2'b00;
            total_cnt++;
            if ({sw_out, rise, fall} !== {exp_out, exp_rise, 2'b00})
                $display("FAIL bounce_settle edge %0d: out=%b rise=%b fall=%b, want out=%b rise=%b fall=00",
                         e, sw_out, rise, fall, exp_out, exp_rise);
            else
                pass_cnt++;
        end
    endtask

    // Both channels fall together, then only channel 1 falls.
    task automatic test_independent_fall();
        sw_in = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] exp_out, exp_fall;
            tick();
            exp_out  = (e >= 6) ? 2'b00 : 2'b11;
            exp_fall = (e == 6) ? 2'b11 : 2'b00;
            total_cnt++;
            if ({sw_out, rise, fall} !== {exp_out, 2'b00, exp_fall})
                $display("FAIL fall_both edge %0d: out=%b rise=%b fall=%b, want out=%b rise=00 fall=%b",
                         e, sw_out, rise, fall, exp_out, exp_fall);
            else
                pass_cnt++;
        end
        sw_in = 2'b11;
        settle(10);
        total_cnt++;
        if (sw_out !== 2'b11)
            $display("FAIL fall_prep: out=%b, want 11", sw_out);
        else
            pass_cnt++;
        sw_in = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] exp_out, exp_fall;
            tick();
            exp_out  = (e >= 6) ? 2'b01 : 2'b11;
            exp_fall = (e == 6) ? 2'b10 : 2'b00;
            total_cnt++;
            if ({sw_out, rise, fall} !== {exp_out, 2'b00, exp_fall})
                $display("FAIL fall_ch1 edge %0d: out=%b rise=%b fall=%b, want out=%b rise=00 fall=%b",
                         e, sw_out, rise, fall, exp_out, exp_fall);
            else
                pass_cnt++;
        end
    endtask

    // Channel 1 rises, reset hits mid-count; full latency restarts after release.
    task automatic test_reset_mid_pending();
        sw_in = 2'b11;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total_cnt++;
            if ({sw_out, rise, fall} !== {2'b01, 2'b00, 2'b00})
                $display("FAIL rst_pending_pre edge %0d: out=%b rise=%b fall=%b, want out=01 rise=00 fall=00",
                         e, sw_out, rise, fall);
            else
                pass_cnt++;
        end
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({sw_out, rise, fall} !== 6'b0)
            $display("FAIL rst_pending_hold: out=%b rise=%b fall=%b, want all 0", sw_out, rise, fall);
        else
            pass_cnt++;
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] exp_out, exp_rise;
            tick();
            exp_out  = (e >= 6) ? 2'b11 : 2'b00;
            exp_rise = (e == 6) ? 2'b11 : 2'b00;
            total_cnt++;
            if ({sw_out, rise, fall} !== {exp_out, exp_rise, 2'b00})
                $display("FAIL rst_pending_release edge %0d: out=%b rise=%b fall=%b, want out=%b rise=%b fall=00",
                         e, sw_out, rise, fall, exp_out, exp_rise);
            else
                pass_cnt++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = 2'b11;
        test_reset();
        test_clean_step();
        test_bounce_reject();
        test_bounce_settle();
        test_independent_fall();
        test_reset_mid_pending();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
